// File: rtl/dmem_stall_responder.sv
// dmem_stall_responder
// Data-memory responder for the core's load/store port. It answers the
// req/gnt/rvalid handshake, does word reads and byte-enabled writes on an
// internal RAM, and can hold off each grant by a configurable number of
// wait states.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   data_req_i        core requests an access
//   data_addr_i       byte address (word index = addr[31:2])
//   data_we_i         1 = store, 0 = load
//   data_be_i         store byte enables, lane k = bits [8k+7:8k]
//   data_wdata_i      store data
//   data_gnt_o        request accepted this cycle (combinational)
//   data_rvalid_o     response valid, one cycle after the grant
//   data_rdata_o      load data (0 for stores and errors)
//   data_err_o        word index out of range
//   stall_en_i        enable wait-state injection
//   stall_cfg_i       wait states inserted before each grant
//   stall_cnt_o       saturating count of cycles with req=1 and gnt=0
module dmem_stall_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int STALL_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               data_req_i,
  input  logic [31:0]        data_addr_i,
  input  logic               data_we_i,
  input  logic [3:0]         data_be_i,
  input  logic [31:0]        data_wdata_i,
  output logic               data_gnt_o,
  output logic               data_rvalid_o,
  output logic [31:0]        data_rdata_o,
  output logic               data_err_o,
  input  logic               stall_en_i,
  input  logic [STALL_W-1:0] stall_cfg_i,
  output logic [15:0]        stall_cnt_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e               state_q;
  logic [STALL_W-1:0]   wait_q;
  logic                 rvalid_q;
  logic [31:0]          rdata_q;
  logic                 err_q;
  logic [15:0]          stall_cnt_q;
  logic [15:0]          stall_cnt_d;

  logic [31:0]          mem [0:MEM_WORDS-1];

  logic [STALL_W-1:0]   load_val;
  logic [29:0]          word_idx;
  logic [IDX_W-1:0]     idx;
  logic                 in_range;
  logic                 gnt;
  logic                 unused_addr_lsb;

  // Byte offset within the word plays no role in a word-wide memory.
  assign unused_addr_lsb = ^data_addr_i[1:0];

  assign load_val = stall_en_i ? stall_cfg_i : '0;
  assign word_idx = data_addr_i[31:2];
  assign idx      = word_idx[IDX_W-1:0];
  assign in_range = (word_idx < 30'(MEM_WORDS));

  // Grant is qualified by rst_n so that nothing is accepted, and no write
  // lands, while reset is held.
  always_comb begin
    gnt = 1'b0;
    if (rst_n && data_req_i) begin
      case (state_q)
        IDLE:    gnt = (load_val == '0);
        WAIT:    gnt = (wait_q == STALL_W'(1));
        default: gnt = 1'b0;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (data_req_i && !gnt && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      // Response stage: one cycle behind the grant, so at most one is
      // ever outstanding and order is preserved trivially.
      rvalid_q    <= gnt;
      err_q       <= gnt && !in_range;
      rdata_q     <= (gnt && !data_we_i && in_range) ? mem[idx] : '0;
      stall_cnt_q <= stall_cnt_d;

      case (state_q)
        IDLE: begin
          // Stall configuration is captured only here, on the first
          // request cycle.
          if (data_req_i) begin
            wait_q <= load_val;
            if (load_val != '0) state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!data_req_i) begin
            // Request withdrawn: abandon it without any access.
            state_q <= IDLE;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q - STALL_W'(1);
            if (wait_q == STALL_W'(1)) state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          wait_q  <= '0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; out-of-range stores are dropped.
  always_ff @(posedge clk) begin
    if (gnt && data_we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) mem[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
      end
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Directed testbench for dmem_stall_responder with a response scoreboard.
module tb_dmem_stall_responder;

  localparam int MEM_WORDS = 1024;
  localparam int STALL_W   = 4;

  logic               clk;
  logic               rst_n;
  logic               req;
  logic [31:0]        addr;
  logic               we;
  logic [3:0]         be;
  logic [31:0]        wdata;
  logic               gnt;
  logic               rvalid;
  logic [31:0]        rdata;
  logic               err;
  logic               stall_en;
  logic [STALL_W-1:0] stall_cfg;
  logic [15:0]        stall_cnt;

  dmem_stall_responder #(.MEM_WORDS(MEM_WORDS), .STALL_W(STALL_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_req_i    (req),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .data_gnt_o    (gnt),
    .data_rvalid_o (rvalid),
    .data_rdata_o  (rdata),
    .data_err_o    (err),
    .stall_en_i    (stall_en),
    .stall_cfg_i   (stall_cfg),
    .stall_cnt_o   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] mdl [0:15];
  logic        exp_rv;
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: inputs were set just after the previous rising edge.
  // At the falling edge the response is compared against the scoreboard and,
  // if the DUT grants, the expected response is pushed and the model updated.
  task automatic cycle(output logic g);
    rsp_t        r;
    logic [29:0] wi;
    logic        e;
    @(negedge clk);
    g = gnt;
    check("rvalid_timing", {31'd0, rvalid}, {31'd0, exp_rv});
    if (rvalid === 1'b1 && exp_rv && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check("rsp_rdata", rdata, r.rdata);
      check("rsp_err", {31'd0, err}, {31'd0, r.err});
    end
    if (g === 1'b1) begin
      wi = addr[31:2];
      e  = (wi >= 30'(MEM_WORDS));
      r.err   = e;
      r.rdata = (!we && !e) ? mdl[wi[3:0]] : 32'd0;
      exp_q.push_back(r);
      if (we && !e) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) mdl[wi[3:0]][8*k +: 8] = wdata[8*k +: 8];
      end
    end
    exp_rv = (g === 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input int exp_wait, input bit hold);
    int   n;
    logic g;
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    n = 0; g = 1'b0;
    while (!g && n < 40) begin
      cycle(g);
      if (!g) n++;
    end
    check("gnt_latency", 32'(n), 32'(exp_wait));
    if (!hold) req = 1'b0;
  endtask

  task automatic drain();
    logic g;
    req = 1'b0;
    for (int i = 0; i < 3; i++) cycle(g);
  endtask

  initial begin
    logic g;
    checks = 0; errors = 0; exp_rv = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
    rst_n = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
    stall_en = 1'b0; stall_cfg = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", {31'd0, gnt}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload words 0..3 through full-word stores, back to back
    access(32'h0, 1'b1, 4'hF, 32'h11223344, 0, 1'b1);
    access(32'h4, 1'b1, 4'hF, 32'h55667788, 0, 1'b1);
    access(32'h8, 1'b1, 4'hF, 32'h99AABBCC, 0, 1'b1);
    access(32'hC, 1'b1, 4'hF, 32'hDDEEFF00, 0, 1'b0);
    drain();

    // Zero-stall load
    access(32'h4, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    drain();

    // Partial store then read-after-write in consecutive grants
    access(32'h0, 1'b1, 4'b0010, 32'hAABBCCDD, 0, 1'b1);
    access(32'h0, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    drain();
    check("raw_model", mdl[0], 32'h1122CC44);

    // Three wait states on a store, then on a load
    stall_en = 1'b1; stall_cfg = 4'd3;
    access(32'h8, 1'b1, 4'hF, 32'hCAFEF00D, 3, 1'b0);
    drain();
    check("stall_cnt_3", {16'd0, stall_cnt}, 32'd3);
    access(32'h8, 1'b0, 4'h0, 32'h0, 3, 1'b0);
    drain();
    check("stall_cnt_6", {16'd0, stall_cnt}, 32'd6);
    stall_en = 1'b0;

    // Back-to-back loads, one per cycle
    access(32'h0, 1'b0, 4'h0, 32'h0, 0, 1'b1);
    access(32'hC, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    drain();

    // Empty byte mask still answers; memory unchanged
    access(32'h8, 1'b1, 4'b0000, 32'h12345678, 0, 1'b1);
    access(32'h8, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    drain();

    // Out-of-range store: err, no write; then verify words 0..3
    access(32'(MEM_WORDS * 4), 1'b1, 4'hF, 32'hFFFFFFFF, 0, 1'b1);
    access(32'h0, 1'b0, 4'h0, 32'h0, 0, 1'b1);
    access(32'h4, 1'b0, 4'h0, 32'h0, 0, 1'b1);
    access(32'h8, 1'b0, 4'h0, 32'h0, 0, 1'b1);
    access(32'hC, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    drain();
    check("stall_cnt_hold", {16'd0, stall_cnt}, 32'd6);

    // Reset during WAIT drops a store that was never granted
    stall_en = 1'b1; stall_cfg = 4'd5;
    req = 1'b1; addr = 32'h4; we = 1'b1; be = 4'hF; wdata = 32'hDEADBEEF;
    cycle(g);
    check("wait_c0_gnt", {31'd0, g}, 32'd0);
    cycle(g);
    check("wait_c1_gnt", {31'd0, g}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gnt", {31'd0, gnt}, 32'd0);
    check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    check("midrst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    req = 1'b0; stall_en = 1'b0; stall_cfg = '0;
    exp_rv = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    access(32'h4, 1'b0, 4'h0, 32'h0, 0, 1'b0);
    drain();
    check("post_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
